// File: rtl/mat_ops_param.sv
// Run-time-shaped matrix engine (transpose/add/scalar/multiply); latency = load beats + compute + result beats.
// Backpressure: in_ready only in LOAD, result index holds while out_ready is low; `define MAT_OPS_SAT_EN to saturate.
module mat_ops_param #(
  parameter int DW      = 8,
  parameter int MAX_DIM = 5,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_op,
  input  logic [2:0]       op_sel,
  input  logic [DIM_W-1:0] dim_a_m,
  input  logic [DIM_W-1:0] dim_a_n,
  input  logic [DIM_W-1:0] dim_b_m,
  input  logic [DIM_W-1:0] dim_b_n,
  input  logic [DW-1:0]    scalar_k,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             busy,
  output logic             op_done,
  output logic             error_flag,
  output logic [1:0]       err_code
);
  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 2 * DIM_W;
  localparam int ACC_W = 2 * DW + DIM_W;

  localparam logic [2:0]       OP_TRN = 3'd0;
  localparam logic [2:0]       OP_ADD = 3'd1;
  localparam logic [2:0]       OP_SCL = 3'd2;
  localparam logic [2:0]       OP_MUL = 3'd3;
  localparam logic [DIM_W-1:0] D_ONE  = DIM_W'(1);
  localparam logic [DIM_W-1:0] D_MAX  = DIM_W'(MAX_DIM);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT, S_DONE, S_ERROR} state_t;
  state_t state, state_nxt;

  logic [2:0]       op_q;
  logic [DIM_W-1:0] am, an, bm, bn;
  logic [DW-1:0]    k_q;
  logic [1:0]       err_q;
  logic [CNT_W-1:0] idx, oi;
  logic [DIM_W-1:0] ri, ci, kk;
  logic [ACC_W-1:0] acc;

  logic [DW-1:0] a_mem [DEPTH];
  logic [DW-1:0] b_mem [DEPTH];
  logic [DW-1:0] c_mem [DEPTH];

  function automatic logic [AW-1:0] addr(input logic [CNT_W-1:0] v);
    return AW'(v);
  endfunction

  function automatic logic [CNT_W-1:0] lin(input logic [DIM_W-1:0] r,
                                           input logic [DIM_W-1:0] w,
                                           input logic [DIM_W-1:0] c);
    return CNT_W'(r) * CNT_W'(w) + CNT_W'(c);
  endfunction

  function automatic logic [DW-1:0] fit(input logic [ACC_W-1:0] v);
`ifdef MAT_OPS_SAT_EN
    logic [ACC_W-1:0] elem_max;
    elem_max = {{(ACC_W-DW){1'b0}}, {DW{1'b1}}};
    if (v > elem_max) return {DW{1'b1}};
`endif
    return v[DW-1:0];
  endfunction

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (d > D_MAX);
  endfunction

  // Command screening runs on the live inputs so the error is known on the start_op edge.
  logic       cmd_uses_b;
  logic [1:0] cmd_err;
  always_comb begin
    cmd_uses_b = (op_sel == OP_ADD) || (op_sel == OP_MUL);
    cmd_err    = 2'd0;
    if (op_sel > OP_MUL)
      cmd_err = 2'd3;
    else if (dim_bad(dim_a_m) || dim_bad(dim_a_n) ||
             (cmd_uses_b && (dim_bad(dim_b_m) || dim_bad(dim_b_n))))
      cmd_err = 2'd1;
    else if ((op_sel == OP_ADD) && ((dim_a_m != dim_b_m) || (dim_a_n != dim_b_n)))
      cmd_err = 2'd2;
    else if ((op_sel == OP_MUL) && (dim_a_n != dim_b_m))
      cmd_err = 2'd2;
  end

  logic             is_mul, uses_b, load_hs, load_last, cmp_last, out_end;
  logic [CNT_W-1:0] na, nb, n_beats, n_out;
  logic [DIM_W-1:0] col_lim;
  always_comb begin
    is_mul    = (op_q == OP_MUL);
    uses_b    = (op_q == OP_ADD) || is_mul;
    na        = CNT_W'(am) * CNT_W'(an);
    nb        = CNT_W'(bm) * CNT_W'(bn);
    n_beats   = (uses_b && (nb > na)) ? nb : na;
    n_out     = is_mul ? CNT_W'(am) * CNT_W'(bn) : na;
    col_lim   = is_mul ? bn : an;
    load_hs   = (state == S_LOAD) && in_valid;
    load_last = (idx == n_beats - C_ONE);
    cmp_last  = (ri == am - D_ONE) && (ci == col_lim - D_ONE) && (!is_mul || (kk == an - D_ONE));
    out_end   = (oi == n_out - C_ONE);
  end

  // Multiply walks (ri, ci, kk) with kk innermost; the other ops walk A row-major via (ri, ci).
  logic [CNT_W-1:0] a_idx, b_idx, c_idx;
  logic [DW-1:0]    a_elem, b_elem, c_dat;
  logic [ACC_W-1:0] prod, acc_sum;
  logic             c_we;
  always_comb begin
    a_idx   = lin(ri, an, is_mul ? kk : ci);
    b_idx   = is_mul ? lin(kk, bn, ci) : a_idx;
    a_elem  = a_mem[addr(a_idx)];
    b_elem  = b_mem[addr(b_idx)];
    prod    = ACC_W'(a_elem) * ACC_W'(is_mul ? b_elem : k_q);
    acc_sum = acc + prod;
    c_we    = (state == S_COMPUTE);
    c_idx   = a_idx;
    c_dat   = a_elem;
    case (op_q)
      OP_TRN: c_idx = lin(ci, am, ri);
      OP_ADD: c_dat = fit(ACC_W'(a_elem) + ACC_W'(b_elem));
      OP_SCL: c_dat = fit(prod);
      default: begin
        c_we  = (state == S_COMPUTE) && (kk == an - D_ONE);
        c_idx = lin(ri, bn, ci);
        c_dat = fit(acc_sum);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    busy       = 1'b0;
    op_done    = 1'b0;
    error_flag = 1'b0;
    case (state)
      S_IDLE: if (start_op) state_nxt = (cmd_err != 2'd0) ? S_ERROR : S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && load_last) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        busy = 1'b1;
        if (cmp_last) state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = c_mem[addr(oi)];
        out_last  = out_end;
        if (out_ready && out_end) state_nxt = S_DONE;
      end
      S_DONE: begin
        op_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERROR: begin
        error_flag = 1'b1;
        if (start_op) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign err_code = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      am    <= '0;
      an    <= '0;
      bm    <= '0;
      bn    <= '0;
      k_q   <= '0;
      err_q <= '0;
      idx   <= '0;
      oi    <= '0;
      ri    <= '0;
      ci    <= '0;
      kk    <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          idx <= '0;
          oi  <= '0;
          ri  <= '0;
          ci  <= '0;
          kk  <= '0;
          acc <= '0;
          if (start_op) begin
            op_q  <= op_sel;
            am    <= dim_a_m;
            an    <= dim_a_n;
            bm    <= dim_b_m;
            bn    <= dim_b_n;
            k_q   <= scalar_k;
            err_q <= cmd_err;
          end
        end
        S_LOAD: if (in_valid) idx <= idx + C_ONE;
        S_COMPUTE: begin
          if (is_mul) begin
            if (kk == an - D_ONE) begin
              kk  <= '0;
              acc <= '0;
              if (ci == bn - D_ONE) begin
                ci <= '0;
                ri <= ri + D_ONE;
              end else begin
                ci <= ci + D_ONE;
              end
            end else begin
              kk  <= kk + D_ONE;
              acc <= acc_sum;
            end
          end else if (ci == an - D_ONE) begin
            ci <= '0;
            ri <= ri + D_ONE;
          end else begin
            ci <= ci + D_ONE;
          end
        end
        S_OUTPUT: if (out_ready) oi <= oi + C_ONE;
        S_ERROR:  if (start_op) err_q <= 2'd0;
        default: ;
      endcase
    end
  end

  // Buffers are plain storage and deliberately survive reset.
  always_ff @(posedge clk) begin
    if (load_hs) begin
      if (idx < na)            a_mem[addr(idx)] <= in_a;
      if (uses_b && (idx < nb)) b_mem[addr(idx)] <= in_b;
    end
    if (c_we) c_mem[addr(c_idx)] <= c_dat;
  end

endmodule

// File: tb/tb_mat_ops_param.sv
// Directed bench for mat_ops_param: every op, error codes, backpressure and mid-load reset.
`timescale 1ns/1ps
module tb_mat_ops_param;
  localparam int DW      = 8;
  localparam int MAX_DIM = 5;
  localparam int DIM_W   = $clog2(MAX_DIM + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_op = 1'b0;
  logic [2:0]       op_sel = '0;
  logic [DIM_W-1:0] dim_a_m = '0, dim_a_n = '0, dim_b_m = '0, dim_b_n = '0;
  logic [DW-1:0]    scalar_k = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_a = '0, in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic             out_last, busy, op_done, error_flag;
  logic [1:0]       err_code;

  mat_ops_param #(.DW(DW), .MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start_op(start_op), .op_sel(op_sel),
    .dim_a_m(dim_a_m), .dim_a_n(dim_a_n), .dim_b_m(dim_b_m), .dim_b_n(dim_b_n),
    .scalar_k(scalar_k), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .op_done(op_done),
    .error_flag(error_flag), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  int            tmo = 0;
  logic [DW-1:0] va [25];
  logic [DW-1:0] vb [25];
  logic [DW-1:0] ex [25];
  logic [DW-1:0] got [25];
  logic          got_last [25];
  int            n_got, wait_cyc, stall_bad;
  logic          done_now, done_next, valid_after;

  task automatic do_reset();
    rst_n = 1'b0; start_op = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [DIM_W-1:0] am, input logic [DIM_W-1:0] an,
                          input logic [DIM_W-1:0] bm, input logic [DIM_W-1:0] bn, input logic [DW-1:0] k);
    op_sel = op; dim_a_m = am; dim_a_n = an; dim_b_m = bm; dim_b_n = bn; scalar_k = k;
    start_op = 1'b1;
    @(negedge clk);
    start_op = 1'b0;
  endtask

  task automatic load_beats(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      t = 0;
      while (!in_ready && t < 100) begin t++; @(negedge clk); end
      if (t >= 100) tmo++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect_out(input int n, input int bp_at);
    int cyc, guard;
    logic [DW-1:0] snap;
    logic snap_last;
    n_got = 0; stall_bad = 0; out_ready = 1'b1; cyc = 0;
    while (!out_valid && cyc < 1000) begin cyc++; @(negedge clk); end
    wait_cyc = cyc;
    if (cyc >= 1000) tmo++;
    guard = 0;
    while (n_got < n && guard < 1000) begin
      guard++;
      if (out_valid) begin
        if (n_got == bp_at) begin
          snap = out_data; snap_last = out_last; out_ready = 1'b0;
          repeat (3) begin
            @(negedge clk);
            if (out_data !== snap || out_last !== snap_last || out_valid !== 1'b1) stall_bad++;
          end
          out_ready = 1'b1;
        end
        got[n_got] = out_data; got_last[n_got] = out_last; n_got++;
      end
      @(negedge clk);
    end
    if (n_got < n) tmo++;
    done_now = op_done; valid_after = out_valid;
    @(negedge clk);
    done_next = op_done;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, in_ready, out_valid, out_last, op_done, error_flag} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {busy, in_ready, out_valid, out_last, op_done, error_flag});
    end
    checks++;
    if (out_data !== 8'd0 || err_code !== 2'd0) begin
      failures++; $display("FAIL reset_data got data=%0d code=%0d exp 0/0", out_data, err_code);
    end
  endtask

  task automatic test_transpose();
    for (int i = 0; i < 6; i++) va[i] = DW'(i + 1);
    ex[0] = 1; ex[1] = 4; ex[2] = 2; ex[3] = 5; ex[4] = 3; ex[5] = 6;
    send_cmd(3'd0, 2, 3, 0, 0, 0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL trn_load_entry got busy=%b in_ready=%b exp 1/1", busy, in_ready);
    end
    load_beats(6);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL trn_in_ready_drop got=%b exp=0", in_ready); end
    collect_out(6, -1);
    checks++;
    if (wait_cyc !== 6) begin failures++; $display("FAIL trn_compute_cycles got=%0d exp=6", wait_cyc); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== ex[i] || got_last[i] !== (i == 5)) begin
        failures++; $display("FAIL trn_beat%0d got=%0d last=%b exp=%0d last=%b", i, got[i], got_last[i], ex[i], (i == 5));
      end
    end
    checks++;
    if (done_now !== 1'b1 || valid_after !== 1'b0 || done_next !== 1'b0) begin
      failures++; $display("FAIL trn_op_done got now=%b valid=%b next=%b exp 1/0/0", done_now, valid_after, done_next);
    end
    checks++;
    if (tmo !== 0) begin failures++; $display("FAIL trn_timeout got=%0d exp=0", tmo); end
  endtask

  task automatic test_add(input int bp_at, input string tag);
    for (int i = 0; i < 4; i++) begin va[i] = DW'(i + 1); vb[i] = DW'(10 * (i + 1)); end
    ex[0] = 11; ex[1] = 22; ex[2] = 33; ex[3] = 44;
    send_cmd(3'd1, 2, 2, 2, 2, 0);
    load_beats(4);
    collect_out(4, bp_at);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== ex[i]) begin failures++; $display("FAIL %s_beat%0d got=%0d exp=%0d", tag, i, got[i], ex[i]); end
    end
    checks++;
    if (stall_bad !== 0 || got_last[3] !== 1'b1 || got_last[2] !== 1'b0) begin
      failures++; $display("FAIL %s_stall got bad=%0d last2=%b last3=%b exp 0/0/1", tag, stall_bad, got_last[2], got_last[3]);
    end
    checks++;
    if (tmo !== 0) begin failures++; $display("FAIL %s_timeout got=%0d exp=0", tag, tmo); end
  endtask

  task automatic test_scalar();
    va[0] = 100; va[1] = 5; vb[0] = 8'hAA; vb[1] = 8'h55;
`ifdef MAT_OPS_SAT_EN
    ex[0] = 255;
`else
    ex[0] = 44;
`endif
    ex[1] = 15;
    send_cmd(3'd2, 1, 2, 0, 0, 3);
    load_beats(2);
    collect_out(2, -1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got[i] !== ex[i]) begin failures++; $display("FAIL scl_beat%0d got=%0d exp=%0d", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_multiply();
    for (int i = 0; i < 6; i++) begin va[i] = DW'(i + 1); vb[i] = DW'(i + 7); end
    ex[0] = 58; ex[1] = 64; ex[2] = 139; ex[3] = 154;
    send_cmd(3'd3, 2, 3, 3, 2, 0);
    load_beats(6);
    collect_out(4, -1);
    checks++;
    if (wait_cyc !== 12) begin failures++; $display("FAIL mul_compute_cycles got=%0d exp=12", wait_cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== ex[i] || got_last[i] !== (i == 3)) begin
        failures++; $display("FAIL mul_beat%0d got=%0d last=%b exp=%0d", i, got[i], got_last[i], ex[i]);
      end
    end
    checks++;
    if (tmo !== 0) begin failures++; $display("FAIL mul_timeout got=%0d exp=0", tmo); end
  endtask

  task automatic test_errors();
    int rdy_seen;
    send_cmd(3'd3, 2, 3, 2, 2, 0);
    checks++;
    if (error_flag !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
      failures++; $display("FAIL err_shape got flag=%b code=%0d busy=%b exp 1/2/0", error_flag, err_code, busy);
    end
    rdy_seen = 0; in_valid = 1'b1;
    repeat (3) begin if (in_ready !== 1'b0 || out_valid !== 1'b0) rdy_seen++; @(negedge clk); end
    in_valid = 1'b0;
    checks++;
    if (rdy_seen !== 0 || err_code !== 2'd2) begin
      failures++; $display("FAIL err_hold got ready_cycles=%0d code=%0d exp 0/2", rdy_seen, err_code);
    end
    send_cmd(3'd0, 1, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (error_flag !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL err_clear got flag=%b code=%0d busy=%b exp 0/0/0", error_flag, err_code, busy);
    end
    send_cmd(3'd7, 0, 2, 0, 0, 0);
    checks++;
    if (err_code !== 2'd3) begin failures++; $display("FAIL err_illegal_op got=%0d exp=3", err_code); end
    send_cmd(3'd0, 0, 0, 0, 0, 0);
    send_cmd(3'd0, 6, 1, 0, 0, 0);
    checks++;
    if (err_code !== 2'd1) begin failures++; $display("FAIL err_dim_big got=%0d exp=1", err_code); end
    send_cmd(3'd0, 0, 0, 0, 0, 0);
    send_cmd(3'd1, 2, 2, 0, 2, 0);
    checks++;
    if (err_code !== 2'd1) begin failures++; $display("FAIL err_dim_zero_b got=%0d exp=1", err_code); end
    send_cmd(3'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_load();
    int dn;
    for (int i = 0; i < 6; i++) va[i] = DW'(i + 1);
    send_cmd(3'd0, 2, 3, 0, 0, 0);
    load_beats(2);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b exp=1", busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, out_last, op_done, error_flag, err_code} !== 8'b0 || out_data !== 8'd0) begin
      failures++; $display("FAIL rst_mid_outputs got=%b data=%0d exp all 0", {busy, in_ready, out_valid, out_last, op_done, error_flag, err_code}, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (5) begin @(negedge clk); if (op_done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) dn++; end
    checks++;
    if (dn !== 0) begin failures++; $display("FAIL rst_mid_idle got=%0d active cycles exp=0", dn); end
  endtask

  task automatic test_back_to_back();
    va[0] = 7; va[1] = 8; va[2] = 9;
    send_cmd(3'd2, 1, 3, 0, 0, 2);
    load_beats(3);
    collect_out(3, 1);
    checks++;
    if (got[0] !== 8'd14 || got[1] !== 8'd16 || got[2] !== 8'd18 || stall_bad !== 0) begin
      failures++; $display("FAIL b2b_first got=%0d,%0d,%0d bad=%0d exp=14,16,18 bad=0", got[0], got[1], got[2], stall_bad);
    end
    va[0] = 200; va[1] = 100;
    vb[0] = 100; vb[1] = 1;
    send_cmd(3'd1, 1, 2, 1, 2, 0);
    load_beats(2);
    collect_out(2, -1);
    checks++;
`ifdef MAT_OPS_SAT_EN
    if (got[0] !== 8'd255 || got[1] !== 8'd101) begin
      failures++; $display("FAIL b2b_add got=%0d,%0d exp=255,101", got[0], got[1]);
    end
`else
    if (got[0] !== 8'd44 || got[1] !== 8'd101) begin
      failures++; $display("FAIL b2b_add got=%0d,%0d exp=44,101", got[0], got[1]);
    end
`endif
    checks++;
    if (tmo !== 0) begin failures++; $display("FAIL b2b_timeout got=%0d exp=0", tmo); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_transpose();
    test_add(-1, "add");
    test_scalar();
    test_multiply();
    test_errors();
    test_add(2, "bp");
    test_reset_mid_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
